// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter clocked at the baud rate: one serial bit per clk cycle.
// Frame = start bit (0), DATA_WIDTH payload bits LSB first, optional parity
// bit, stop bit (1). TX_OUT and busy are registered and are loaded from the
// next-state decision, so every line bit lasts exactly one clk cycle.
//
// Handshake: Data_Valid is a strobe that is only looked at while idle. A
// high Data_Valid on an IDLE edge latches P_DATA/PAR_EN/PAR_TYP and starts
// a frame; any strobe while busy=1 (including the stop cycle) is dropped,
// so upstream must hold or re-present it until busy falls. At least one
// idle cycle (TX_OUT=1, busy=0) always separates two frames.
//
// Optional build macro: UART_TX_DOUBLE_STOP_EN
//   defined   -> two stop bits per frame (1-bit stop counter added)
//   undefined -> one stop bit, no extra flops
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  ARST_n,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_tx_out;
  logic                  r_busy;
`ifdef UART_TX_DOUBLE_STOP_EN
  logic                  r_stop_cnt;
`endif

  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_parity;

  // Parity always from the latched payload; odd type inverts the even bit.
  assign w_parity  = (^r_data) ^ r_par_typ;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  assign TX_OUT = r_tx_out;
  assign busy   = r_busy;

  // Frame sequencer: state, bit counter, latched payload and registered line outputs.
  always_ff @(posedge clk or negedge ARST_n) begin
    if (!ARST_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_DOUBLE_STOP_EN
      r_stop_cnt <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          if (Data_Valid) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_state   <= START;
            r_tx_out  <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        START: begin
          r_state  <= DATA;
          r_tx_out <= r_data[0];
          r_cnt    <= '0;
        end
        DATA: begin
          if (r_cnt == LAST_BIT) begin
            if (r_par_en) begin
              r_state  <= PARITY;
              r_tx_out <= w_parity;
            end else begin
              r_state  <= STOP;
              r_tx_out <= 1'b1;
            end
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_tx_out <= r_data[w_cnt_nxt];
          end
        end
        PARITY: begin
          r_state  <= STOP;
          r_tx_out <= 1'b1;
        end
        STOP: begin
          r_tx_out <= 1'b1;
`ifdef UART_TX_DOUBLE_STOP_EN
          if (!r_stop_cnt) begin
            r_stop_cnt <= 1'b1;
          end else begin
            r_stop_cnt <= 1'b0;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          // Unreachable encodings recover to a quiet idle line.
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
`ifdef UART_TX_DOUBLE_STOP_EN
          r_stop_cnt <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
